// File: rtl/led_fb_write_arbiter.sv
// Frame-buffer write arbiter: parses UART command bytes into a small FIFO and
// round-robins them against a valid/ready host port onto the single write port.
module led_fb_write_arbiter #(
    parameter int QDEPTH = 4,
    parameter int QAW    = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           uart_rx_dv,
    input  logic [7:0]     uart_rx_data,
    input  logic           host_valid,
    output logic           host_ready,
    input  logic [1:0]     host_op,
    input  logic [7:0]     host_addr,
    input  logic           fb_hold,
    output logic           fb_we,
    output logic [1:0]     fb_op,
    output logic [7:0]     fb_addr,
    output logic           fb_src,
    output logic           uart_ovf,
    input  logic           uart_ovf_clr,
    output logic [QAW:0]   uart_q_level
);

    // state  | meaning
    // P_CTRL | expecting a control byte
    // P_SET  | next byte is the address of a SET command
    // P_CLR  | next byte is the address of a CLR command
    typedef enum logic [1:0] {P_CTRL, P_SET, P_CLR} parse_t;

    localparam logic [1:0] OP_COLOUR = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLR    = 2'b10;
    localparam logic [1:0] OP_CLRALL = 2'b11;
    localparam logic [QAW:0] C_FULL  = (QAW+1)'(QDEPTH);

    parse_t           r_pstate;
    parse_t           w_pstate_nxt;
    logic             w_dec_vld;
    logic [1:0]       w_dec_op;
    logic [7:0]       w_dec_addr;
    logic             r_push_vld;
    logic [1:0]       r_push_op;
    logic [7:0]       r_push_addr;

    logic [9:0]       r_mem [QDEPTH];
    logic [QAW-1:0]   r_wr_ptr;
    logic [QAW-1:0]   r_rd_ptr;
    logic [QAW:0]     r_count;
    logic             r_ovf;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [9:0]       w_head;

    logic             r_last_grant;
    logic             w_uart_pend;
    logic             w_host_pend;
    logic             w_grant_uart;
    logic             w_grant_host;

    logic             r_fb_we;
    logic [1:0]       r_fb_op;
    logic [7:0]       r_fb_addr;
    logic             r_fb_src;

    // Parser: decode runs in the strobe cycle, the push is registered so it
    // reaches the FIFO one cycle later.
    always_comb begin
        w_pstate_nxt = r_pstate;
        w_dec_vld    = 1'b0;
        w_dec_op     = OP_COLOUR;
        w_dec_addr   = 8'h00;
        if (uart_rx_dv) begin
            case (r_pstate)
                P_CTRL: begin
                    case (uart_rx_data[7:4])
                        4'h0: begin
                            w_dec_vld  = 1'b1;
                            w_dec_op   = OP_COLOUR;
                            w_dec_addr = {5'b0, uart_rx_data[2:0]};
                        end
                        4'h1: w_pstate_nxt = P_SET;
                        4'h2: w_pstate_nxt = P_CLR;
                        4'h3: begin
                            w_dec_vld  = 1'b1;
                            w_dec_op   = OP_CLRALL;
                            w_dec_addr = 8'h00;
                        end
                        default: ;
                    endcase
                end
                P_SET: begin
                    w_dec_vld    = 1'b1;
                    w_dec_op     = OP_SET;
                    w_dec_addr   = uart_rx_data;
                    w_pstate_nxt = P_CTRL;
                end
                P_CLR: begin
                    w_dec_vld    = 1'b1;
                    w_dec_op     = OP_CLR;
                    w_dec_addr   = uart_rx_data;
                    w_pstate_nxt = P_CTRL;
                end
                default: w_pstate_nxt = P_CTRL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pstate    <= P_CTRL;
            r_push_vld  <= 1'b0;
            r_push_op   <= 2'b00;
            r_push_addr <= 8'h00;
        end else begin
            r_pstate    <= w_pstate_nxt;
            r_push_vld  <= w_dec_vld;
            r_push_op   <= w_dec_op;
            r_push_addr <= w_dec_addr;
        end
    end

    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_pop   = w_grant_uart;
    // When full, the write slot is the head slot; the head is consumed this
    // cycle so overwriting it on a simultaneous pop is safe.
    assign w_push  = r_push_vld && (!w_full || w_pop);
    assign w_drop  = r_push_vld && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= {r_push_op, r_push_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + QAW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + QAW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (QAW+1)'(1);
                2'b01:   r_count <= r_count - (QAW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (uart_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign w_uart_pend = !w_empty;
    assign w_host_pend = host_valid;

    // r_last_grant: 1 = host was last winner of a contended cycle.
    always_comb begin
        w_grant_uart = 1'b0;
        w_grant_host = 1'b0;
        if (!reset && !fb_hold) begin
            if (w_uart_pend && w_host_pend) begin
                if (r_last_grant) begin
                    w_grant_uart = 1'b1;
                end else begin
                    w_grant_host = 1'b1;
                end
            end else if (w_uart_pend) begin
                w_grant_uart = 1'b1;
            end else if (w_host_pend) begin
                w_grant_host = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_uart_pend && w_host_pend && (w_grant_uart || w_grant_host)) begin
            r_last_grant <= w_grant_host;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fb_we   <= 1'b0;
            r_fb_op   <= 2'b00;
            r_fb_addr <= 8'h00;
            r_fb_src  <= 1'b0;
        end else begin
            r_fb_we <= w_grant_uart || w_grant_host;
            if (w_grant_uart) begin
                r_fb_op   <= w_head[9:8];
                r_fb_addr <= w_head[7:0];
                r_fb_src  <= 1'b0;
            end else if (w_grant_host) begin
                r_fb_op   <= host_op;
                r_fb_addr <= host_addr;
                r_fb_src  <= 1'b1;
            end
        end
    end

    assign host_ready   = w_grant_host;
    assign fb_we        = r_fb_we;
    assign fb_op        = r_fb_op;
    assign fb_addr      = r_fb_addr;
    assign fb_src       = r_fb_src;
    assign uart_ovf     = r_ovf;
    assign uart_q_level = r_count;

endmodule

// File: tb/tb_led_fb_write_arbiter.sv
// Bench for led_fb_write_arbiter: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_led_fb_write_arbiter;
    localparam int QDEPTH = 4;
    localparam int QAW    = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           uart_rx_dv;
    logic [7:0]     uart_rx_data;
    logic           host_valid;
    logic           host_ready;
    logic [1:0]     host_op;
    logic [7:0]     host_addr;
    logic           fb_hold;
    logic           fb_we;
    logic [1:0]     fb_op;
    logic [7:0]     fb_addr;
    logic           fb_src;
    logic           uart_ovf;
    logic           uart_ovf_clr;
    logic [QAW:0]   uart_q_level;

    always #5 clk = ~clk;

    led_fb_write_arbiter #(.QDEPTH(QDEPTH), .QAW(QAW)) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rx_dv   (uart_rx_dv),
        .uart_rx_data (uart_rx_data),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_op      (host_op),
        .host_addr    (host_addr),
        .fb_hold      (fb_hold),
        .fb_we        (fb_we),
        .fb_op        (fb_op),
        .fb_addr      (fb_addr),
        .fb_src       (fb_src),
        .uart_ovf     (uart_ovf),
        .uart_ovf_clr (uart_ovf_clr),
        .uart_q_level (uart_q_level)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: parser mode, pending command, FIFO as a queue, flags.
    int          m_ps   = 0;     // 0 control byte, 1 SET address, 2 CLR address
    bit          m_pv   = 1'b0;
    logic [9:0]  m_pc   = '0;
    logic [9:0]  m_q[$];
    bit          m_ovf  = 1'b0;
    bit          m_last = 1'b1;  // 1: host won the last contended cycle
    bit          m_we   = 1'b0;
    logic [1:0]  m_op   = '0;
    logic [7:0]  m_addr = '0;
    bit          m_src  = 1'b0;

    logic [10:0] wr_log[$];      // {src, op, addr} of every observed write

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int         g;
        bit         up;
        bit         hp;
        logic [9:0] hd;
        @(negedge clk);
        up = (m_q.size() != 0);
        hp = host_valid;
        g  = 0;
        if (!reset && !fb_hold) begin
            if (up && hp)  g = m_last ? 1 : 2;
            else if (up)   g = 1;
            else if (hp)   g = 2;
        end
        chk("host_ready",   16'(host_ready),   16'(g == 2));
        chk("fb_we",        16'(fb_we),        16'(m_we));
        chk("fb_op",        16'(fb_op),        16'(m_op));
        chk("fb_addr",      16'(fb_addr),      16'(m_addr));
        chk("fb_src",       16'(fb_src),       16'(m_src));
        chk("uart_ovf",     16'(uart_ovf),     16'(m_ovf));
        chk("uart_q_level", 16'(uart_q_level), 16'(m_q.size()));
        if (fb_we) wr_log.push_back({fb_src, fb_op, fb_addr});

        if (reset) begin
            m_ps = 0; m_pv = 1'b0; m_q.delete(); m_ovf = 1'b0; m_last = 1'b1;
            m_we = 1'b0; m_op = '0; m_addr = '0; m_src = 1'b0;
        end else begin
            m_we = (g != 0);
            if (g == 1) begin
                hd = m_q.pop_front();
                m_op = hd[9:8]; m_addr = hd[7:0]; m_src = 1'b0;
            end else if (g == 2) begin
                m_op = host_op; m_addr = host_addr; m_src = 1'b1;
            end
            if (uart_ovf_clr) m_ovf = 1'b0;
            if (m_pv) begin
                if (m_q.size() < QDEPTH) m_q.push_back(m_pc);
                else m_ovf = 1'b1;
            end
            if (up && hp && g != 0) m_last = (g == 2);
            m_pv = 1'b0;
            if (uart_rx_dv) begin
                if (m_ps == 1 || m_ps == 2) begin
                    m_pv = 1'b1;
                    m_pc = {(m_ps == 1) ? 2'b01 : 2'b10, uart_rx_data};
                    m_ps = 0;
                end else begin
                    case (uart_rx_data[7:4])
                        4'h0: begin m_pv = 1'b1; m_pc = {2'b00, 5'b0, uart_rx_data[2:0]}; end
                        4'h1: m_ps = 1;
                        4'h2: m_ps = 2;
                        4'h3: begin m_pv = 1'b1; m_pc = {2'b11, 8'h00}; end
                        default: ;
                    endcase
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic uart_byte(input logic [7:0] b);
        uart_rx_dv   = 1'b1;
        uart_rx_data = b;
        tick();
        uart_rx_dv   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] hi;
        int         k;
        reset = 1'b1; uart_rx_dv = 1'b0; uart_rx_data = '0; host_valid = 1'b0;
        host_op = '0; host_addr = '0; fb_hold = 1'b0; uart_ovf_clr = 1'b0;
        @(posedge clk);
        #1;
        tick();
        reset = 1'b0;

        // In-order UART commands, host idle
        uart_byte(8'h05); uart_byte(8'h12); uart_byte(8'h3A); uart_byte(8'h31);
        idle(6);
        chk("t1_count", 16'(wr_log.size()), 16'd3);
        chk("t1_w0", 16'(wr_log[0]), 16'h005);
        chk("t1_w1", 16'(wr_log[1]), 16'h13A);
        chk("t1_w2", 16'(wr_log[2]), 16'h300);

        // Round-robin against a continuously valid host
        do_reset();
        fb_hold = 1'b1;
        uart_byte(8'h01); uart_byte(8'h02); uart_byte(8'h03);
        idle(2);
        wr_log.delete();
        host_valid = 1'b1; host_op = 2'b01; host_addr = 8'h11; fb_hold = 1'b0;
        idle(5);
        host_valid = 1'b0;
        idle(2);
        chk("t2_count", 16'(wr_log.size()), 16'd5);
        chk("t2_s0", 16'(wr_log[0][10]), 16'd0);
        chk("t2_s1", 16'(wr_log[1]), 16'h511);
        chk("t2_s2", 16'(wr_log[2][10]), 16'd0);
        chk("t2_s3", 16'(wr_log[3][10]), 16'd1);
        chk("t2_s4", 16'(wr_log[4][10]), 16'd0);

        // Overflow under hold, then drain
        do_reset();
        fb_hold = 1'b1;
        for (int i = 1; i <= 6; i++) uart_byte(8'(i));
        idle(2);
        chk("t3_level", 16'(uart_q_level), 16'd4);
        chk("t3_ovf",   16'(uart_ovf),     16'd1);
        chk("t3_we",    16'(fb_we),        16'd0);
        fb_hold = 1'b0;
        wr_log.delete();
        idle(6);
        chk("t3_writes", 16'(wr_log.size()), 16'd4);
        chk("t3_ovf_kept", 16'(uart_ovf), 16'd1);
        uart_ovf_clr = 1'b1;
        tick();
        uart_ovf_clr = 1'b0;
        chk("t3_ovf_clr", 16'(uart_ovf), 16'd0);

        // CLR with 0xFx address; reset in the middle of a command
        do_reset();
        wr_log.delete();
        uart_byte(8'h20); uart_byte(8'hF3);
        idle(4);
        chk("t4_clr_n", 16'(wr_log.size()), 16'd1);
        chk("t4_clr",   16'(wr_log[0]), 16'h2F3);
        wr_log.delete();
        uart_byte(8'h10);
        do_reset();
        chk("t4_level", 16'(uart_q_level), 16'd0);
        uart_byte(8'h07);
        idle(4);
        chk("t4_col_n", 16'(wr_log.size()), 16'd1);
        chk("t4_col",   16'(wr_log[0]), 16'h007);

        // Push into a full FIFO in the same cycle as a pop
        do_reset();
        fb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) uart_byte(8'(i));
        idle(2);
        wr_log.delete();
        uart_byte(8'h05);
        fb_hold = 1'b0;
        tick();
        chk("t5_ovf",   16'(uart_ovf),     16'd0);
        chk("t5_level", 16'(uart_q_level), 16'd4);
        idle(8);
        chk("t5_n",    16'(wr_log.size()), 16'd5);
        chk("t5_first", 16'(wr_log[0]), 16'h001);
        chk("t5_last", 16'(wr_log[4]), 16'h005);

        // Host-only CLR latency
        do_reset();
        host_valid = 1'b1; host_op = 2'b10; host_addr = 8'h44;
        #1;
        chk("t6_ready", 16'(host_ready), 16'd1);
        tick();
        host_valid = 1'b0;
        chk("t6_we",   16'(fb_we),   16'd1);
        chk("t6_op",   16'(fb_op),   16'd2);
        chk("t6_addr", 16'(fb_addr), 16'h44);
        chk("t6_src",  16'(fb_src),  16'd1);
        idle(2);

        // Random traffic
        do_reset();
        repeat (600) begin
            k  = $urandom_range(0, 5);
            hi = (k == 5) ? 4'($urandom) : ((k == 4) ? 4'hF : 4'(k));
            uart_rx_dv   = ($urandom_range(0, 1) == 0);
            uart_rx_data = {hi, 4'($urandom)};
            host_valid   = ($urandom_range(0, 2) == 0);
            host_op      = 2'($urandom);
            host_addr    = 8'($urandom);
            fb_hold      = ($urandom_range(0, 3) == 0);
            uart_ovf_clr = ($urandom_range(0, 15) == 0);
            reset        = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; uart_rx_dv = 1'b0; host_valid = 1'b0; fb_hold = 1'b0; uart_ovf_clr = 1'b0;
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
